// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - CPU-side push port and FIFO status of the buffered UART transmitter
interface uart_tx_buffered_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (
        output wr_en, wr_data,
        input  full, empty, count, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered 8N1 UART transmitter draining bytes back-to-back
module uart_tx_buffered #(
    parameter int CLK_HZ     = 1000000,
    parameter int BAUD       = 9600,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                 clk_from_FPGA,
    input  logic                 rst_from_FPGA,
    uart_tx_buffered_if.slave    bus,
    output logic                 busy,
    output logic                 uart_tx_pin_for_FPGA
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int TW    = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [TW-1:0]         TMAX    = TW'(DIV - 1);
    localparam logic [TW-1:0]         T_ONE   = TW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             mem_q [DEPTH];
    logic [7:0]             mem_d [DEPTH];

    logic full, has_data, push, pop, last_tick;
    logic [7:0] head;

    assign full      = (count_q == CNT_MAX);
    assign has_data  = (count_q != '0);
    assign push      = bus.wr_en && !full;
    assign head      = mem_q[rd_ptr_q];
    assign last_tick = (timer_q == TMAX);

    // Full is judged on the registered count, so a same-cycle pop never rescues a push.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (bus.wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        count_d = count_q + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (has_data) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    timer_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (last_tick) begin
                    timer_d   = '0;
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            DATA: begin
                if (last_tick) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            STOP: begin
                if (last_tick) begin
                    timer_d = '0;
                    // Chain straight into the next start bit so bursts have no idle gap.
                    if (has_data) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + T_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_from_FPGA) begin
        if (rst_from_FPGA) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_from_FPGA) begin
        mem_q <= mem_d;
    end

    assign bus.full             = full;
    assign bus.empty            = !has_data;
    assign bus.count            = count_q;
    assign bus.overflow         = overflow_q;
    assign busy                 = (state_q != IDLE);
    assign uart_tx_pin_for_FPGA = tx_q;
endmodule
